// File: rtl/cdu_count_receiver.sv
`timescale 1ns/1ps
// cdu_count_receiver
// AGC-side receiver for one CDU channel. Synchronizes the CDU's asynchronous
// plus/minus angle-increment pulses, accumulates them into a wrapping two's
// complement counter, and serves snapshots over a request/valid handshake.
// Also drives the AGC-to-CDU command levels and runs the zero sequence that
// clears the counter in step with the CDU read counter.
//
// Ports:
//   CLOCKH    system clock (rising edge)
//   rst_n     asynchronous active-low reset
//   ATpPGH    async plus-increment pulse from CDU
//   ATmPGH    async minus-increment pulse from CDU
//   zero_req  one-cycle request to start the zero sequence
//   ca_en     coarse-align enable level
//   eec_en    error-counter enable level
//   rd_req    one-cycle counter read request
//   AGCZ      zero command to CDU (high ZPULSE cycles per zero)
//   AGCCA     registered coarse-align command
//   AGCEEC    registered error-counter enable, low while zeroing
//   z_busy    high while the zero sequence is active
//   rd_valid  one-cycle read strobe
//   rd_data   counter snapshot
//   ovf       sticky wrap flags {neg, pos}
module cdu_count_receiver #(
    parameter int WIDTH   = 15,
    parameter int ZPULSE  = 8,
    parameter int ZSETTLE = 4
) (
    input  logic             CLOCKH,
    input  logic             rst_n,
    input  logic             ATpPGH,
    input  logic             ATmPGH,
    input  logic             zero_req,
    input  logic             ca_en,
    input  logic             eec_en,
    input  logic             rd_req,
    output logic             AGCZ,
    output logic             AGCCA,
    output logic             AGCEEC,
    output logic             z_busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       ovf
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ZERO   = 2'b01;
    localparam logic [1:0] ST_SETTLE = 2'b10;

    localparam int ZMAX = (ZPULSE > ZSETTLE) ? ZPULSE : ZSETTLE;
    localparam int CW   = $clog2(ZMAX + 1);

    localparam logic signed [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Bit 0 carries the plus channel, bit 1 the minus channel.
    logic [1:0]              pgh_p0;
    logic [1:0]              pgh_p1;
    logic [1:0]              pgh_p2;
    logic [1:0]              evt;

    logic signed [WIDTH-1:0] count;
    logic [1:0]              ovf_q;
    logic [1:0]              ovf_snap;
    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [CW-1:0]           zcnt;
    logic [CW-1:0]           zcnt_nxt;
    logic                    cnt_live;

    // Wrapping single-step update; simultaneous plus and minus cancel.
    function automatic logic signed [WIDTH-1:0] count_step(
        input logic signed [WIDTH-1:0] c,
        input logic                    up,
        input logic                    dn
    );
        if (up && !dn)
            return c + CNT_ONE;
        else if (dn && !up)
            return c - CNT_ONE;
        else
            return c;
    endfunction

    // Which wrap (if any) this step causes: {neg, pos}.
    function automatic logic [1:0] wrap_flags(
        input logic signed [WIDTH-1:0] c,
        input logic                    up,
        input logic                    dn
    );
        return {dn && !up && (c == CNT_MIN), up && !dn && (c == CNT_MAX)};
    endfunction

    // Stage p0/p1: two-flop synchronizer; stage p2: history for edge detect.
    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            pgh_p0 <= 2'b00;
            pgh_p1 <= 2'b00;
            pgh_p2 <= 2'b00;
        end else begin
            pgh_p0 <= {ATmPGH, ATpPGH};
            pgh_p1 <= pgh_p0;
            pgh_p2 <= pgh_p1;
        end
    end

    assign evt = pgh_p1 & ~pgh_p2;

    // Zero sequencer: ZERO holds AGCZ for ZPULSE cycles, SETTLE absorbs
    // the CDU's post-zero transients for ZSETTLE cycles.
    always_comb begin
        state_nxt = state;
        zcnt_nxt  = zcnt;
        case (state)
            ST_IDLE: begin
                if (zero_req) begin
                    state_nxt = ST_ZERO;
                    zcnt_nxt  = '0;
                end
            end
            ST_ZERO: begin
                if (zcnt == CW'(ZPULSE - 1)) begin
                    state_nxt = (ZSETTLE == 0) ? ST_IDLE : ST_SETTLE;
                    zcnt_nxt  = '0;
                end else begin
                    zcnt_nxt = zcnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (zcnt == CW'(ZSETTLE - 1)) begin
                    state_nxt = ST_IDLE;
                    zcnt_nxt  = '0;
                end else begin
                    zcnt_nxt = zcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                zcnt_nxt  = '0;
            end
        endcase
    end

    // Counting only happens in IDLE when no zero is being launched.
    assign cnt_live = (state == ST_IDLE) && !zero_req;

    // Counter, flags, read snapshot and command registers.
    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            zcnt     <= '0;
            count    <= '0;
            ovf_q    <= 2'b00;
            ovf_snap <= 2'b00;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            AGCCA    <= 1'b0;
            AGCEEC   <= 1'b0;
        end else begin
            state    <= state_nxt;
            zcnt     <= zcnt_nxt;
            rd_valid <= rd_req;
            AGCCA    <= ca_en;
            AGCEEC   <= eec_en && (state_nxt == ST_IDLE);

            // Snapshot takes pre-update values; flags clear on the read
            // edge, but a wrap on that same edge re-sets them.
            if (rd_req) begin
                rd_data  <= count;
                ovf_snap <= ovf_q;
            end

            if (cnt_live) begin
                count <= count_step(count, evt[0], evt[1]);
                ovf_q <= (rd_req ? 2'b00 : ovf_q) | wrap_flags(count, evt[0], evt[1]);
            end else begin
                count <= '0;
                ovf_q <= 2'b00;
            end
        end
    end

    assign AGCZ   = (state == ST_ZERO);
    assign z_busy = (state != ST_IDLE);
    // During the read strobe show the flags as they were before the clear.
    assign ovf    = rd_valid ? ovf_snap : ovf_q;

endmodule

// File: tb/tb_cdu_count_receiver.sv
`timescale 1ns/1ps
module tb_cdu_count_receiver;

    logic        CLOCKH;
    logic        rst_n;
    logic        ATpPGH;
    logic        ATmPGH;
    logic        zero_req;
    logic        ca_en;
    logic        eec_en;
    logic        rd_req;
    logic        AGCZ;
    logic        AGCCA;
    logic        AGCEEC;
    logic        z_busy;
    logic        rd_valid;
    logic [14:0] rd_data;
    logic [1:0]  ovf;

    int          checks = 0;
    int          errors = 0;
    int          model  = 0;      // reference count as a plain integer
    logic [1:0]  ovf_m  = 2'b00;  // reference sticky flags {neg, pos}

    cdu_count_receiver #(.WIDTH(15), .ZPULSE(8), .ZSETTLE(4)) dut (
        .CLOCKH   (CLOCKH),
        .rst_n    (rst_n),
        .ATpPGH   (ATpPGH),
        .ATmPGH   (ATmPGH),
        .zero_req (zero_req),
        .ca_en    (ca_en),
        .eec_en   (eec_en),
        .rd_req   (rd_req),
        .AGCZ     (AGCZ),
        .AGCCA    (AGCCA),
        .AGCEEC   (AGCEEC),
        .z_busy   (z_busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ovf      (ovf)
    );

    initial CLOCKH = 1'b0;
    always #5 CLOCKH = ~CLOCKH;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCKH);
        #1;
    endtask

    // Reference: add the net increment, wrap into [-16384, 16383], note wraps.
    task automatic apply(input int dp, input int dm);
        int raw;
        raw = model + dp - dm;
        if (raw > 16383) begin
            ovf_m[0] = 1'b1;
            raw -= 32768;
        end
        if (raw < -16384) begin
            ovf_m[1] = 1'b1;
            raw += 32768;
        end
        model = raw;
    endtask

    task automatic pulse(input logic p, input logic m, input int gap);
        ATpPGH = p;
        ATmPGH = m;
        step();
        ATpPGH = 1'b0;
        ATmPGH = 1'b0;
        repeat (gap) step();
        apply(int'(p), int'(m));
    endtask

    task automatic do_read(input string tag);
        logic [14:0] e;
        e = model[14:0];
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(e));
        chk({tag, "_ovf"}, 32'(ovf), 32'(ovf_m));
        ovf_m = 2'b00;
        step();
        chk({tag, "_valid_end"}, 32'(rd_valid), 32'd0);
        chk({tag, "_ovf_cleared"}, 32'(ovf), 32'(ovf_m));
    endtask

    task automatic do_zero();
        zero_req = 1'b1;
        step();
        zero_req = 1'b0;
        repeat (12) step();
        model = 0;
        ovf_m = 2'b00;
    endtask

    initial begin
        int zb;
        int zc;
        int eec_bad;
        int n;
        int kind;
        int gap;

        rst_n    = 1'b0;
        ATpPGH   = 1'b0;
        ATmPGH   = 1'b0;
        zero_req = 1'b0;
        ca_en    = 1'b1;
        eec_en   = 1'b1;
        rd_req   = 1'b0;
        repeat (3) @(posedge CLOCKH);
        #1;

        // Reset state, with command enables already high.
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_agcz", 32'(AGCZ), 32'd0);
        chk("rst_agcca", 32'(AGCCA), 32'd0);
        chk("rst_agceec", 32'(AGCEEC), 32'd0);
        chk("rst_z_busy", 32'(z_busy), 32'd0);

        rst_n = 1'b1;
        step();
        chk("agcca_follow", 32'(AGCCA), 32'd1);
        chk("agceec_follow", 32'(AGCEEC), 32'd1);
        ca_en  = 1'b0;
        eec_en = 1'b0;
        step();
        chk("agcca_low", 32'(AGCCA), 32'd0);
        chk("agceec_low", 32'(AGCEEC), 32'd0);
        do_read("init");

        // Simultaneous plus and minus cancel.
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1, 3);
        repeat (2) step();
        do_read("cancel");

        // 5 plus, 2 minus, 4-cycle spacing.
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 3);
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1, 3);
        repeat (2) step();
        do_read("plus5_minus2");

        // Randomized pulse mixes against the reference model.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(10, 30);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 2);
                gap  = $urandom_range(1, 3);
                pulse(kind != 1, kind != 0, gap);
            end
            repeat (2) step();
            do_read("random");
        end

        // Zero sequence from count 7, with pulses and a stray zero_req inside.
        do_zero();
        for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1);
        repeat (2) step();
        do_read("pre_zero7");
        eec_en = 1'b1;
        ca_en  = 1'b1;
        step();
        chk("eec_before_zero", 32'(AGCEEC), 32'd1);
        zero_req = 1'b1;
        step();
        zero_req = 1'b0;
        zb = 0;
        zc = 0;
        eec_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!z_busy) break;
            zb++;
            if (AGCZ) zc++;
            if (AGCEEC) eec_bad++;
            ATpPGH   = (i < 8) && (i % 2 == 0);
            zero_req = (i == 3);
            step();
        end
        ATpPGH   = 1'b0;
        zero_req = 1'b0;
        chk("agcz_cycles", 32'(zc), 32'd8);
        chk("z_busy_cycles", 32'(zb), 32'd12);
        chk("eec_forced_low", 32'(eec_bad), 32'd0);
        chk("eec_after_zero", 32'(AGCEEC), 32'd1);
        chk("agcca_hold", 32'(AGCCA), 32'd1);
        model = 0;
        ovf_m = 2'b00;
        repeat (3) step();
        do_read("post_zero");

        // Read on the same edge as an update from 9.
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1);
        repeat (2) step();
        ATpPGH = 1'b1;
        step();
        ATpPGH = 1'b0;
        step();
        rd_req = 1'b1;
        step();
        chk("same_edge_valid", 32'(rd_valid), 32'd1);
        chk("same_edge_old", 32'(rd_data), 32'd9);
        step();
        rd_req = 1'b0;
        chk("same_edge_next", 32'(rd_data), 32'd10);
        apply(1, 0);
        step();
        do_read("after_same_edge");

        // Positive wrap; a read coinciding with the wrap keeps the flag set.
        do_zero();
        for (int i = 0; i < 16383; i++) pulse(1'b1, 1'b0, 1);
        repeat (2) step();
        do_read("pre_wrap");
        ATpPGH = 1'b1;
        step();
        ATpPGH = 1'b0;
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("wrap_edge_data", 32'(rd_data), 32'h3fff);
        chk("wrap_edge_ovf", 32'(ovf), 32'd0);
        step();
        chk("wrap_set_wins", 32'(ovf), 32'd1);
        apply(1, 0);
        do_read("wrap_pos");
        do_read("wrap_cleared");

        // Negative wrap back to max positive.
        pulse(1'b0, 1'b1, 1);
        repeat (2) step();
        do_read("wrap_neg");

        // Reset in the third ZERO cycle with the plus input held high.
        zero_req = 1'b1;
        step();
        zero_req = 1'b0;
        step();
        step();
        chk("mid_zero_agcz", 32'(AGCZ), 32'd1);
        ATpPGH = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_agcz", 32'(AGCZ), 32'd0);
        chk("async_z_busy", 32'(z_busy), 32'd0);
        chk("async_agceec", 32'(AGCEEC), 32'd0);
        repeat (2) @(posedge CLOCKH);
        #1;
        rst_n = 1'b1;
        model = 0;
        ovf_m = 2'b00;
        repeat (3) step();
        ATpPGH = 1'b0;
        repeat (3) step();
        apply(1, 0);
        do_read("held_through_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
